chess_turn_controller: RTL
==========================

// Module: chess_turn_controller
// PURPOSE
//  Sequences the two players' minute/second counter chains of the chess clock.
//  Generates the 1 s decrement pulses and routes clock-enable and decrement to the player on move.
//  Tracks turn, pause and timeout; latches the flag of the player whose time ran out.
//  Sits between the debounced buttons and the two counter chains; its per-player outputs drive CE and decrement inputs.
// PARAMETERS
//  SEC_DIV  100_000_000  CLK cycles per 1 s tick (must be >= 2; prescaler width $clog2(SEC_DIV))
// PORTS
//  CLK     in   1  system clock, rising edge
//  CLR     in   1  asynchronous, active-high reset
//  START   in   1  1-cycle pulse: start from IDLE / resume from PAUSED
//  PAUSE   in   1  1-cycle pulse: pause running clock
//  BTN_A   in   1  1-cycle pulse: player A finished move
//  BTN_B   in   1  1-cycle pulse: player B finished move
//  ZERO_A  in   1  player A chain reads 00:00 (level)
//  ZERO_B  in   1  player B chain reads 00:00 (level)
//  CE_A    out  1  enable for player A chain
//  CE_B    out  1  enable for player B chain
//  TICK_A  out  1  1-cycle decrement impulse to player A seconds counter
//  TICK_B  out  1  1-cycle decrement impulse to player B seconds counter
//  ACTIVE  out  1  player on move: 0 = A, 1 = B
//  STATE   out  2  00 IDLE, 01 RUN, 10 PAUSED, 11 TIMEOUT
//  FLAG_A  out  1  latched: A lost on time
//  FLAG_B  out  1  latched: B lost on time
// BEHAVIOUR
//  - CLR (async): STATE=IDLE, ACTIVE=0, prescaler=0; all of CE_*, TICK_*, FLAG_* = 0. Applies mid-operation, no clock edge needed.
//  - All outputs registered or decoded from registers only; no combinational input-to-output path.
//  - CE_A = (STATE==RUN && ACTIVE==0); CE_B = (STATE==RUN && ACTIVE==1).
//  - IDLE: START -> RUN, ACTIVE=0, prescaler=0. All other inputs ignored.
//  - RUN: per-cycle priority, highest first:
//    1 ZERO of active player -> TIMEOUT, set its FLAG, no tick.
//    2 PAUSE -> PAUSED, prescaler holds its value.
//    3 BTN of active player -> ACTIVE toggles, prescaler=0, tick due this cycle suppressed.
//    4 prescaler==SEC_DIV-1 -> prescaler=0, TICK of active player high next cycle, exactly 1 cycle.
//    5 else prescaler+1.
//  - RUN: BTN of non-active player, START and ZERO of non-active player ignored.
//  - RUN timing: START sampled at edge 0 -> first TICK_A high after edge SEC_DIV; then every SEC_DIV cycles.
//  - PAUSED: START -> RUN, prescaler resumes from held value. BTN_*, PAUSE and ZERO_* ignored.
//  - TIMEOUT: terminal state. CE_* = 0, TICK_* = 0. FLAG held; only CLR exits.
//  - At most one TICK_* is high in any cycle. TICK_* is never high while STATE != RUN, except the single registered pulse that follows an edge-RUN tick.
// TESTING (SEC_DIV=4)
//  1 CLR, then START -> STATE=01, CE_A=1, CE_B=0; TICK_A high after edges 4, 8, 12; TICK_B stays 0.
//  2 RUN, A active, BTN_A at prescaler=2 -> ACTIVE=1, CE_B=1; TICK_B 4 edges later. BTN_A now ignored.
//  3 PAUSE at prescaler=2, wait 10 cycles, START -> no ticks while paused; TICK_A 2 edges after resume.
//  4 B active, ZERO_B=1 -> STATE=11, FLAG_B=1, CE_A=CE_B=0. Later START/BTN_* -> no change until CLR.
//  5 BTN_A in same cycle as prescaler==3 -> no TICK_A, ACTIVE=1, prescaler=0.
//  6 CLR raised mid-RUN between clock edges -> STATE=00, all outputs 0 immediately, before next edge.

Source files
------------

// File: rtl/chess_turn_controller.sv
// Chess clock turn controller: 1 s prescaler, turn/pause/timeout FSM, per-player CE and decrement routing.
// All outputs registered or decoded from state; ticks appear one cycle after the wrapping edge; no backpressure.
module chess_turn_controller #(
  parameter int SEC_DIV = 100_000_000
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       START,
  input  logic       PAUSE,
  input  logic       BTN_A,
  input  logic       BTN_B,
  input  logic       ZERO_A,
  input  logic       ZERO_B,
  output logic       CE_A,
  output logic       CE_B,
  output logic       TICK_A,
  output logic       TICK_B,
  output logic       ACTIVE,
  output logic [1:0] STATE,
  output logic       FLAG_A,
  output logic       FLAG_B
);

  localparam int PW = $clog2(SEC_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(SEC_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_RUN     = 2'b01,
    S_PAUSED  = 2'b10,
    S_TIMEOUT = 2'b11
  } state_t;

  state_t          state_q, state_d;
  logic            active_q, active_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic            tick_a_q, tick_a_d;
  logic            tick_b_q, tick_b_d;
  logic            flag_a_q, flag_a_d;
  logic            flag_b_q, flag_b_d;
  logic            zero_mine;
  logic            btn_mine;

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q  <= S_IDLE;
      active_q <= 1'b0;
      presc_q  <= '0;
      tick_a_q <= 1'b0;
      tick_b_q <= 1'b0;
      flag_a_q <= 1'b0;
      flag_b_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      presc_q  <= presc_d;
      tick_a_q <= tick_a_d;
      tick_b_q <= tick_b_d;
      flag_a_q <= flag_a_d;
      flag_b_q <= flag_b_d;
    end
  end

  // Only the player on move can time out or hand over the turn.
  assign zero_mine = active_q ? ZERO_B : ZERO_A;
  assign btn_mine  = active_q ? BTN_B  : BTN_A;

  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    presc_d  = presc_q;
    tick_a_d = 1'b0;
    tick_b_d = 1'b0;
    flag_a_d = flag_a_q;
    flag_b_d = flag_b_q;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d  = S_RUN;
          active_d = 1'b0;
          presc_d  = '0;
        end
      end
      S_RUN: begin
        if (zero_mine) begin
          state_d = S_TIMEOUT;
          if (active_q) flag_b_d = 1'b1;
          else          flag_a_d = 1'b1;
        end else if (PAUSE) begin
          state_d = S_PAUSED;
        end else if (btn_mine) begin
          // Handing over the move restarts the second and drops any tick due now.
          active_d = ~active_q;
          presc_d  = '0;
        end else if (presc_q == PRESC_LAST) begin
          presc_d  = '0;
          tick_a_d = ~active_q;
          tick_b_d = active_q;
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      S_PAUSED: begin
        if (START) state_d = S_RUN;
      end
      S_TIMEOUT: begin
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    STATE  = state_q;
    ACTIVE = active_q;
    CE_A   = (state_q == S_RUN) && !active_q;
    CE_B   = (state_q == S_RUN) && active_q;
    TICK_A = tick_a_q;
    TICK_B = tick_b_q;
    FLAG_A = flag_a_q;
    FLAG_B = flag_b_q;
  end

endmodule
